// File: rtl/uart_mem_ctrl_if.sv
// Bus bundle between the UART memory controller and its surroundings:
// mode controls, UART RX/TX byte streams, memory strobes and status flags.
interface uart_mem_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              uart_on;
    logic              uart_mode;
    logic              uart_ram_id;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              tx_busy;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              mem_we;
    logic              mem_re;
    logic              mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              cpu_hold;
    logic              im_done;
    logic              dm_done;
    logic              dump_done;

    modport master (
        output uart_on, uart_mode, uart_ram_id, rx_valid, rx_data, tx_busy, mem_rdata,
        input  tx_start, tx_data, mem_we, mem_re, mem_sel, mem_addr, mem_wdata,
        input  cpu_hold, im_done, dm_done, dump_done
    );

    modport slave (
        input  uart_on, uart_mode, uart_ram_id, rx_valid, rx_data, tx_busy, mem_rdata,
        output tx_start, tx_data, mem_we, mem_re, mem_sel, mem_addr, mem_wdata,
        output cpu_hold, im_done, dm_done, dump_done
    );
endinterface

// File: rtl/uart_mem_ctrl.sv
// Loads instruction/data memory from UART RX bytes (little-endian words) or
// dumps it to UART TX, holding the CPU in reset while the UART owns memory.
module uart_mem_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int IM_WORDS = 10,
    parameter int DM_WORDS = 3
) (
    input logic           clk,
    input logic           reset,
    uart_mem_ctrl_if.slave bus
);

    localparam int MAX_WORDS = (IM_WORDS > DM_WORDS) ? IM_WORDS : DM_WORDS;
    localparam int CNT_W     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

    typedef enum logic [2:0] {
        IDLE, LOAD, DUMP_RD, DUMP_LAT, DUMP_TX, DUMP_ARM, DUMP_WAIT, DONE
    } state_t;

    state_t            state_q, state_d;
    logic              sel_q, sel_d;
    logic              armed_q, armed_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        byte_q, byte_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       send_q, send_d;
    logic              mem_we_q, mem_we_d;
    logic              im_done_q, im_done_d;
    logic              dm_done_q, dm_done_d;
    logic              dump_done_q, dump_done_d;

    logic [CNT_W-1:0]  n_last;
    logic              last_word;

    assign n_last    = sel_q ? CNT_W'(DM_WORDS - 1) : CNT_W'(IM_WORDS - 1);
    assign last_word = (cnt_q == n_last);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            armed_q     <= 1'b0;
            addr_q      <= '0;
            cnt_q       <= '0;
            byte_q      <= 2'd0;
            wdata_q     <= 32'd0;
            send_q      <= 32'd0;
            mem_we_q    <= 1'b0;
            im_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            dump_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            armed_q     <= armed_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            byte_q      <= byte_d;
            wdata_q     <= wdata_d;
            send_q      <= send_d;
            mem_we_q    <= mem_we_d;
            im_done_q   <= im_done_d;
            dm_done_q   <= dm_done_d;
            dump_done_q <= dump_done_d;
        end
    end

    // armed_q records that uart_on was seen low, so a start needs a fresh 0->1.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        armed_d     = armed_q | ~bus.uart_on;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        byte_d      = byte_q;
        wdata_d     = wdata_q;
        send_d      = send_q;
        mem_we_d    = 1'b0;
        im_done_d   = im_done_q;
        dm_done_d   = dm_done_q;
        dump_done_d = dump_done_q;

        case (state_q)
            IDLE: begin
                if (bus.uart_on && armed_q) begin
                    armed_d = 1'b0;
                    sel_d   = bus.uart_ram_id;
                    addr_d  = '0;
                    cnt_d   = '0;
                    byte_d  = 2'd0;
                    if (bus.uart_mode) begin
                        dump_done_d = 1'b0;
                        state_d     = DUMP_RD;
                    end else begin
                        if (bus.uart_ram_id) dm_done_d = 1'b0;
                        else                 im_done_d = 1'b0;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (mem_we_q) begin
                    addr_d = addr_q + ADDR_W'(1);
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (last_word) begin
                        state_d = DONE;
                        if (sel_q) dm_done_d = 1'b1;
                        else       im_done_d = 1'b1;
                    end
                end
                // A byte landing in the write cycle already belongs to the next word.
                if (bus.rx_valid && !(mem_we_q && last_word)) begin
                    wdata_d[{byte_q, 3'b000} +: 8] = bus.rx_data;
                    byte_d = byte_q + 2'd1;
                    if (byte_q == 2'd3) mem_we_d = 1'b1;
                end
            end
            DUMP_RD:  state_d = DUMP_LAT;
            DUMP_LAT: begin
                send_d  = bus.mem_rdata;
                byte_d  = 2'd0;
                state_d = DUMP_TX;
            end
            DUMP_TX:  if (!bus.tx_busy) state_d = DUMP_ARM;
            DUMP_ARM: state_d = DUMP_WAIT;
            DUMP_WAIT: begin
                if (!bus.tx_busy) begin
                    if (byte_q == 2'd3) begin
                        byte_d = 2'd0;
                        if (last_word) begin
                            state_d     = DONE;
                            dump_done_d = 1'b1;
                        end else begin
                            addr_d  = addr_q + ADDR_W'(1);
                            cnt_d   = cnt_q + CNT_W'(1);
                            state_d = DUMP_RD;
                        end
                    end else begin
                        byte_d  = byte_q + 2'd1;
                        state_d = DUMP_TX;
                    end
                end
            end
            DONE: state_d = DONE;
            default: state_d = IDLE;
        endcase

        // Losing uart_on abandons the operation with status left as it was.
        if (state_q != IDLE && !bus.uart_on) begin
            state_d     = IDLE;
            mem_we_d    = 1'b0;
            byte_d      = 2'd0;
            addr_d      = addr_q;
            cnt_d       = cnt_q;
            im_done_d   = im_done_q;
            dm_done_d   = dm_done_q;
            dump_done_d = dump_done_q;
        end
    end

    assign bus.tx_start  = (state_q == DUMP_TX) && !bus.tx_busy && bus.uart_on;
    assign bus.tx_data   = (state_q == DUMP_TX) ? send_q[{byte_q, 3'b000} +: 8] : 8'h00;
    assign bus.mem_re    = (state_q == DUMP_RD) && bus.uart_on;
    assign bus.mem_we    = mem_we_q && bus.uart_on;
    assign bus.mem_sel   = sel_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_hold  = reset && (bus.uart_on || state_q != IDLE);
    assign bus.im_done   = im_done_q;
    assign bus.dm_done   = dm_done_q;
    assign bus.dump_done = dump_done_q;

endmodule

// File: tb/tb_uart_mem_ctrl.sv
// Randomised bench for uart_mem_ctrl: a queue-based model predicts memory
// writes, transmitted bytes and status flags from the byte streams it sends.
module tb_uart_mem_ctrl;
    localparam int ADDR_W   = 8;
    localparam int IM_WORDS = 10;
    localparam int DM_WORDS = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;

    uart_mem_ctrl_if #(.ADDR_W(ADDR_W)) bus();

    uart_mem_ctrl #(.ADDR_W(ADDR_W), .IM_WORDS(IM_WORDS), .DM_WORDS(DM_WORDS)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic              sel;
        bit                last;
    } wr_t;

    int          vectors = 0;
    int          miscompares = 0;
    wr_t         exp_wr[$];
    logic [7:0]  exp_tx[$];
    logic [31:0] we_log[$];
    logic [7:0]  tx_log[$];
    logic [31:0] model_mem [2][2**ADDR_W];
    bit          exp_im_done = 0, exp_dm_done = 0, exp_dump_done = 0;
    int          cyc = 0, last_start = -100, flag_chk = 0;
    bit          re_pending = 0;
    logic [ADDR_W-1:0] re_addr;
    logic        re_sel;
    bit          start_seen = 0;
    int          busy_len = 0, busy_cnt = 0;
    wr_t         cmp_e;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Per-cycle compare against the model queues
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            if (flag_chk != 0) begin
                checkOutput("done_flag_rise", 32'(flag_chk == 1 ? bus.im_done : bus.dm_done), 32'd1);
                flag_chk = 0;
            end
            checkOutput("strobe_exclusive",
                        32'((32'(bus.mem_we) + 32'(bus.mem_re) + 32'(bus.tx_start)) <= 1), 32'd1);
            if (bus.mem_we) begin
                we_log.push_back(bus.mem_wdata);
                if (exp_wr.size() == 0) checkOutput("unexpected_we", 32'd1, 32'd0);
                else begin
                    cmp_e = exp_wr.pop_front();
                    checkOutput("we_addr", 32'(bus.mem_addr), 32'(cmp_e.addr));
                    checkOutput("we_data", bus.mem_wdata, cmp_e.data);
                    checkOutput("we_sel", 32'(bus.mem_sel), 32'(cmp_e.sel));
                    if (cmp_e.last) begin
                        checkOutput("done_flag_low_at_last_we",
                                    32'(cmp_e.sel ? bus.dm_done : bus.im_done), 32'd0);
                        flag_chk = cmp_e.sel ? 2 : 1;
                    end
                end
            end
            if (bus.tx_start) begin
                tx_log.push_back(bus.tx_data);
                start_seen = 1;
                checkOutput("tx_while_busy", 32'(bus.tx_busy), 32'd0);
                checkOutput("tx_spacing", 32'((cyc - last_start) >= 3), 32'd1);
                last_start = cyc;
                if (exp_tx.size() == 0) checkOutput("unexpected_tx", 32'd1, 32'd0);
                else checkOutput("tx_data", 32'(bus.tx_data), 32'(exp_tx.pop_front()));
            end
            if (bus.mem_re) begin
                re_pending = 1;
                re_addr    = bus.mem_addr;
                re_sel     = bus.mem_sel;
            end
        end
    end

    // Memory answers one cycle after mem_re; otherwise returns noise
    always @(posedge clk) begin
        #1;
        if (re_pending) begin
            bus.mem_rdata = model_mem[re_sel][re_addr];
            re_pending = 0;
        end else begin
            bus.mem_rdata = $urandom;
        end
    end

    // Transmitter goes busy for busy_len cycles starting the cycle after tx_start
    always @(posedge clk) begin
        #1;
        if (start_seen) begin
            start_seen = 0;
            if (busy_len > 0) begin
                bus.tx_busy = 1'b1;
                busy_cnt = busy_len;
            end
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) bus.tx_busy = 1'b0;
        end
    end

    task automatic toPhase();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        toPhase();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
        repeat (gap) toPhase();
    endtask

    task automatic checkFlags(input string tag);
        checkOutput({tag, "_im_done"}, 32'(bus.im_done), 32'(exp_im_done));
        checkOutput({tag, "_dm_done"}, 32'(bus.dm_done), 32'(exp_dm_done));
        checkOutput({tag, "_dump_done"}, 32'(bus.dump_done), 32'(exp_dump_done));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_tx_start"}, 32'(bus.tx_start), 32'd0);
        checkOutput({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
        checkOutput({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
        checkOutput({tag, "_mem_re"}, 32'(bus.mem_re), 32'd0);
        checkOutput({tag, "_mem_sel"}, 32'(bus.mem_sel), 32'd0);
        checkOutput({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        checkOutput({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        checkOutput({tag, "_cpu_hold"}, 32'(bus.cpu_hold), 32'd0);
        checkOutput({tag, "_im_done"}, 32'(bus.im_done), 32'd0);
        checkOutput({tag, "_dm_done"}, 32'(bus.dm_done), 32'd0);
        checkOutput({tag, "_dump_done"}, 32'(bus.dump_done), 32'd0);
    endtask

    task automatic startOp(input logic mode, input logic id);
        bus.uart_on     = 1'b1;
        bus.uart_mode   = mode;
        bus.uart_ram_id = id;
        toPhase();
        bus.uart_mode   = 1'($urandom);
        bus.uart_ram_id = 1'($urandom);
        if (mode) exp_dump_done = 0;
        else if (id) exp_dm_done = 0;
        else exp_im_done = 0;
    endtask

    task automatic endOp();
        bus.uart_on = 1'b0;
        toPhase();
        @(negedge clk);
        checkOutput("cpu_hold_released", 32'(bus.cpu_hold), 32'd0);
        checkFlags("idle");
        toPhase();
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while ((exp_wr.size() != 0 || exp_tx.size() != 0) && n < budget) begin
            toPhase();
            n++;
        end
        checkOutput("drain_pending", 32'(exp_wr.size() + exp_tx.size()), 32'd0);
        exp_wr.delete();
        exp_tx.delete();
    endtask

    task automatic runLoad(input logic id, input int nw, input bit abort,
                           input bit pin_first, input logic [31:0] first);
        logic [31:0]       w;
        logic [ADDR_W-1:0] a;
        wr_t               e;
        startOp(1'b0, id);
        for (int i = 0; i < nw; i++) begin
            w = (i == 0 && pin_first) ? first : $urandom;
            a = ADDR_W'(i);
            model_mem[id][a] = w;
            e.addr = a; e.data = w; e.sel = id; e.last = (i == nw - 1) && !abort;
            exp_wr.push_back(e);
            for (int k = 0; k < 4; k++)
                applyStimulus(w[8*k +: 8], (i < 2) ? 0 : $urandom_range(0, 2));
        end
        if (abort) begin
            applyStimulus(8'($urandom), 1);
            applyStimulus(8'($urandom), 0);
            endOp();
            waitDrain(20);
            repeat (10) toPhase();
        end else begin
            waitDrain(200);
            toPhase();
            toPhase();
            if (id) exp_dm_done = 1; else exp_im_done = 1;
            @(negedge clk);
            checkFlags("load_done");
            checkOutput("cpu_hold_in_done", 32'(bus.cpu_hold), 32'd1);
            toPhase();
            endOp();
        end
    endtask

    task automatic runDump(input logic id, input int blen);
        int n;
        busy_len = blen;
        n = id ? DM_WORDS : IM_WORDS;
        for (int i = 0; i < n; i++)
            for (int k = 0; k < 4; k++)
                exp_tx.push_back(model_mem[id][ADDR_W'(i)][8*k +: 8]);
        startOp(1'b1, id);
        waitDrain(n * 4 * (blen + 10) + 50);
        repeat (blen + 6) toPhase();
        exp_dump_done = 1;
        @(negedge clk);
        checkFlags("dump_done");
        toPhase();
        endOp();
    endtask

    initial begin
        int n, sz;
        bus.uart_on = 0; bus.uart_mode = 0; bus.uart_ram_id = 0;
        bus.rx_valid = 0; bus.rx_data = 0; bus.tx_busy = 0; bus.mem_rdata = 0;
        for (int a = 0; a < 2**ADDR_W; a++) begin
            model_mem[0][a] = $urandom;
            model_mem[1][a] = $urandom;
        end
        #12;
        checkAllZero("in_reset");
        @(posedge clk); #1;
        reset = 1'b1;
        toPhase(); toPhase();
        @(negedge clk);
        checkFlags("after_reset");
        toPhase();

        $display("[TB] load instruction memory");
        we_log.delete();
        runLoad(1'b0, IM_WORDS, 0, 1, 32'h12345678);
        checkOutput("im_write_count", 32'(we_log.size()), 32'd10);
        checkOutput("im_first_word", we_log[0], 32'h12345678);

        $display("[TB] load data memory");
        we_log.delete();
        runLoad(1'b1, DM_WORDS, 0, 1, 32'hAABBCCDD);
        checkOutput("dm_write_count", 32'(we_log.size()), 32'd3);

        $display("[TB] dump data memory");
        tx_log.delete();
        runDump(1'b1, 50);
        checkOutput("dump_tx_count", 32'(tx_log.size()), 32'd12);
        checkOutput("dump_byte0", 32'(tx_log[0]), 32'hDD);
        checkOutput("dump_byte1", 32'(tx_log[1]), 32'hCC);
        checkOutput("dump_byte2", 32'(tx_log[2]), 32'hBB);
        checkOutput("dump_byte3", 32'(tx_log[3]), 32'hAA);

        $display("[TB] abort mid-word");
        we_log.delete();
        runLoad(1'b0, 1, 1, 0, 32'd0);
        checkOutput("abort_write_count", 32'(we_log.size()), 32'd1);

        $display("[TB] random operations");
        for (int r = 0; r < 6; r++) begin
            if ($urandom_range(0, 1) == 1) runDump(1'($urandom), $urandom_range(0, 4));
            else begin
                logic id;
                id = 1'($urandom);
                runLoad(id, id ? DM_WORDS : IM_WORDS, 0, 0, 32'd0);
            end
        end

        $display("[TB] reset during dump");
        busy_len = 50;
        for (int i = 0; i < DM_WORDS; i++)
            for (int k = 0; k < 4; k++)
                exp_tx.push_back(model_mem[1][ADDR_W'(i)][8*k +: 8]);
        sz = tx_log.size();
        startOp(1'b1, 1'b1);
        n = 0;
        while (tx_log.size() == sz && n < 100) begin
            toPhase();
            n++;
        end
        checkOutput("tx_before_reset", 32'(tx_log.size() - sz), 32'd1);
        repeat (5) toPhase();
        reset = 1'b0;
        #1;
        checkAllZero("mid_dump_reset");
        exp_tx.delete();
        exp_im_done = 0; exp_dm_done = 0; exp_dump_done = 0;
        toPhase(); toPhase();
        reset = 1'b1;
        sz = tx_log.size();
        repeat (100) toPhase();
        checkOutput("tx_after_reset", 32'(tx_log.size() - sz), 32'd0);
        endOp();
        runLoad(1'b1, DM_WORDS, 0, 0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
